controle_pc: RTL and testbench
==============================

Name: controle_pc

Overview:
- Next-PC sequencer for the single-cycle core.
- Sits in front of the pc register: consumes `atual_Pc` and produces `proximo_Pc` every cycle.
- Arbitrates between sequential, branch, jump/call, return, trap, mret, stall and halt requests with fixed priority.
- Owns the exception PC (`epc`) and a small return-address stack (RAS).

Parameters:
- XLEN, 32, PC/address width.
- RESET_VEC, 32'h00000000, first fetch address after reset.
- TRAP_VEC, 32'h00000100, trap handler address.
- RAS_DEPTH, 4, return-address stack entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- atual_Pc  in  XLEN  current PC from pc register.
- branch_taken  in  1  conditional branch resolved taken.
- branch_alvo  in  XLEN  branch target.
- jump  in  1  unconditional jump.
- call  in  1  jump that pushes a return address.
- jump_alvo  in  XLEN  jump/call target; also the ret fallback.
- ret  in  1  return; pops RAS.
- trap  in  1  exception/interrupt request.
- mret  in  1  return from trap.
- stall  in  1  hold PC this cycle.
- halt  in  1  enter halt.
- proximo_Pc  out  XLEN  next PC to the pc register.
- epc  out  XLEN  saved trap PC.
- instr_valida  out  1  current instruction may commit.
- halted  out  1  high in HALT.
- ras_vazio  out  1  RAS count == 0.
- ras_cheio  out  1  RAS count == RAS_DEPTH.
- ras_miss  out  1  1-cycle pulse when ret hits an empty RAS.

Behaviour:

Clocking and reset:
- All state updates on posedge clk.
- `proximo_Pc`, `instr_valida` and `ras_miss` are combinational from state and inputs.
- rst (synchronous, any state, mid-operation included): next edge gives state=BOOT, epc=0, RAS count=0, top pointer=0. RAS storage is not cleared.
- While rst is high: proximo_Pc=RESET_VEC, instr_valida=0, halted=0, ras_miss=0.

FSM states: BOOT, RUN, TRAP, HALT.
- BOOT:
  - proximo_Pc=RESET_VEC, instr_valida=0.
  - Goes to RUN after 1 cycle; all requests are ignored.
- RUN: instr_valida=1. Priority, highest first:
  1. trap, or misaligned selected target (bits[1:0]!=0): epc<=atual_Pc, proximo_Pc=TRAP_VEC, next state TRAP.
  2. halt: proximo_Pc=atual_Pc, next state HALT.
  3. stall: proximo_Pc=atual_Pc; no RAS or epc change.
  4. mret: proximo_Pc=epc.
  5. ret:
     - RAS non-empty: proximo_Pc=top, then pop.
     - RAS empty: proximo_Pc=jump_alvo, ras_miss=1, count stays 0.
     - ret and call together: pop then push atual_Pc+4 (top replaced, count unchanged); proximo_Pc=old top, or jump_alvo if empty.
  6. call: proximo_Pc=jump_alvo, push atual_Pc+4.
     - RAS full: oldest entry overwritten (circular buffer), count saturates at RAS_DEPTH.
  7. jump: proximo_Pc=jump_alvo.
  8. branch_taken: proximo_Pc=branch_alvo.
  9. Otherwise: proximo_Pc=atual_Pc+4, wrapping modulo 2^XLEN (32'hFFFFFFFC -> 0).
- TRAP:
  - One bubble: proximo_Pc=atual_Pc (TRAP_VEC), instr_valida=0.
  - All inputs ignored, including a second trap. Goes to RUN.
- HALT:
  - proximo_Pc=atual_Pc, instr_valida=0, halted=1.
  - trap wakes the core: epc<=atual_Pc+4, proximo_Pc=TRAP_VEC, next state TRAP. All other inputs are ignored.

Decomposition:
- Package controle_pc_pkg: state enum (BOOT, RUN, TRAP, HALT), default RESET_VEC/TRAP_VEC constants, the PC increment constant (4), and a next-PC source-select enum (SEQ, BR, JMP, RET, EPC, TVEC, HOLD).
- Sub-module pilha_retorno: circular RAS with push, pop, simultaneous push+pop, and count/full/empty/top outputs.
- The FSM and priority mux stay in controle_pc.

Test Plan:
1. Reset, then 3 idle cycles -> proximo_Pc 0x0 (BOOT, instr_valida=0), then 0x4, 0x8; halted=0, ras_vazio=1.
2. atual_Pc=0x20, branch_taken=1, branch_alvo=0x40 with jump=1 and jump_alvo=0x80 in the same cycle -> proximo_Pc=0x80. Then stall=1 at 0x80 -> 0x80 held.
3. Five calls from 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4) -> ras_cheio=1. Five rets -> targets 0x54, 0x44, 0x34, 0x24, then jump_alvo with ras_miss=1 on the 5th.
4. trap at atual_Pc=0x1C -> epc=0x1C, proximo_Pc=0x100, then one TRAP cycle with instr_valida=0. A trap during the TRAP cycle is ignored. mret -> proximo_Pc=0x1C.
5. halt at 0x60 -> PC held at 0x60, halted=1. stall/jump ignored. trap -> epc=0x64, proximo_Pc=0x100.
6. jump to 0x42 (misaligned) at 0x30 -> trap with epc=0x30. Also: rst asserted in HALT with RAS count 2 -> next cycle BOOT, ras_vazio=1. atual_Pc=0xFFFFFFFC with no request -> proximo_Pc=0x0.

Source files
------------

// File: rtl/controle_pc_pkg.sv
// Shared types and constants for the next-PC sequencer and its return-address stack.
package controle_pc_pkg;

    typedef enum logic [1:0] {BOOT, RUN, TRAP, HALT} estado_t;

    // Where proximo_Pc comes from in the current cycle.
    typedef enum logic [2:0] {SEQ, BR, JMP, RET, EPC, TVEC, HOLD} fonte_t;

    localparam logic [31:0] RESET_VEC_PADRAO = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_PADRAO  = 32'h0000_0100;
    localparam int          PC_INC           = 4;

endpackage

// File: rtl/controle_pc_if.sv
// Bundle between the core datapath (master) and the next-PC sequencer (slave).
// No valid/ready handshake: every request is a level sampled each cycle, and the
// sequencer answers combinationally on proximo_Pc in the same cycle.
interface controle_pc_if #(parameter int XLEN = 32);
    import controle_pc_pkg::*;

    logic [XLEN-1:0] atual_Pc;
    logic            branch_taken;
    logic [XLEN-1:0] branch_alvo;
    logic            jump;
    logic            call;
    logic [XLEN-1:0] jump_alvo;
    logic            ret;
    logic            trap;
    logic            mret;
    logic            stall;
    logic            halt;
    logic [XLEN-1:0] proximo_Pc;
    logic [XLEN-1:0] epc;
    logic            instr_valida;
    logic            halted;
    logic            ras_vazio;
    logic            ras_cheio;
    logic            ras_miss;
    estado_t         estado;

    modport master (
        output atual_Pc, branch_taken, branch_alvo, jump, call, jump_alvo,
               ret, trap, mret, stall, halt,
        input  proximo_Pc, epc, instr_valida, halted, ras_vazio, ras_cheio,
               ras_miss, estado
    );

    modport slave (
        input  atual_Pc, branch_taken, branch_alvo, jump, call, jump_alvo,
               ret, trap, mret, stall, halt,
        output proximo_Pc, epc, instr_valida, halted, ras_vazio, ras_cheio,
               ras_miss, estado
    );

endinterface

// File: rtl/pilha_retorno.sv
// Circular return-address stack: when full, a push silently overwrites the oldest entry.
module pilha_retorno #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] dado,
    output logic [XLEN-1:0] topo,
    output logic            vazio,
    output logic            cheio
);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW:0]     cnt;
    logic [PW-1:0]   wr_idx;
    logic            faz_pop;

    assign vazio   = (cnt == '0);
    assign cheio   = (cnt == (PW+1)'(DEPTH));
    assign topo    = mem[ptr];
    assign faz_pop = pop && !vazio;
    // Push+pop replaces the top in place; a plain push goes one slot above it.
    assign wr_idx  = faz_pop ? ptr : ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push && !faz_pop) begin
            ptr <= ptr + 1'b1;
            if (!cheio) cnt <= cnt + 1'b1;
        end else if (faz_pop && !push) begin
            ptr <= ptr - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_idx] <= dado;
    end

endmodule

// File: rtl/controle_pc.sv
// Next-PC sequencer: fixed-priority request arbitration, trap/halt FSM, epc and RAS ownership.
module controle_pc
    import controle_pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_PADRAO,
    parameter logic [XLEN-1:0] TRAP_VEC  = TRAP_VEC_PADRAO,
    parameter int              RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    controle_pc_if.slave bus
);
    estado_t         estado, nxt;
    fonte_t          sel, cand;
    logic [XLEN-1:0] epc_q, epc_d, cand_pc, seq_pc, topo;
    logic            epc_we, push, pop, miss, valida, vazio, cheio;

    assign seq_pc = bus.atual_Pc + XLEN'(PC_INC);

    function automatic logic [XLEN-1:0] pc_de(input fonte_t s);
        case (s)
            SEQ:     return seq_pc;
            BR:      return bus.branch_alvo;
            JMP:     return bus.jump_alvo;
            RET:     return topo;
            EPC:     return epc_q;
            TVEC:    return TRAP_VEC;
            default: return bus.atual_Pc;
        endcase
    endfunction

    pilha_retorno #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .dado(seq_pc),
        .topo(topo), .vazio(vazio), .cheio(cheio)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= BOOT;
            epc_q  <= '0;
        end else begin
            estado <= nxt;
            if (epc_we) epc_q <= epc_d;
        end
    end

    always_comb begin
        nxt     = estado;
        sel     = HOLD;
        cand    = HOLD;
        cand_pc = '0;
        valida  = 1'b0;
        miss    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        epc_we  = 1'b0;
        epc_d   = bus.atual_Pc;
        case (estado)
            BOOT: nxt = RUN;
            RUN: begin
                valida = 1'b1;
                if (bus.halt || bus.stall) cand = HOLD;
                else if (bus.mret)         cand = EPC;
                else if (bus.ret)          cand = vazio ? JMP : RET;
                else if (bus.call || bus.jump) cand = JMP;
                else if (bus.branch_taken) cand = BR;
                else                       cand = SEQ;
                cand_pc = pc_de(cand);
                // A misaligned target never reaches the fetch; it traps at the current PC.
                if (bus.trap || cand_pc[1:0] != 2'b00) begin
                    sel    = TVEC;
                    epc_we = 1'b1;
                    nxt    = TRAP;
                end else begin
                    sel = cand;
                    if (bus.halt) nxt = HALT;
                    else if (!bus.stall && !bus.mret) begin
                        if (bus.ret) begin
                            miss = vazio;
                            pop  = 1'b1;
                        end
                        push = bus.call;
                    end
                end
            end
            TRAP: nxt = RUN;
            HALT: begin
                if (bus.trap) begin
                    sel    = TVEC;
                    epc_we = 1'b1;
                    epc_d  = seq_pc;
                    nxt    = TRAP;
                end
            end
            default: nxt = BOOT;
        endcase
        if (rst) begin
            nxt    = BOOT;
            valida = 1'b0;
            miss   = 1'b0;
            push   = 1'b0;
            pop    = 1'b0;
            epc_we = 1'b0;
        end
    end

    assign bus.proximo_Pc   = (rst || estado == BOOT) ? RESET_VEC : pc_de(sel);
    assign bus.epc          = epc_q;
    assign bus.instr_valida = valida;
    assign bus.halted       = (estado == HALT) && !rst;
    assign bus.ras_vazio    = vazio;
    assign bus.ras_cheio    = cheio;
    assign bus.ras_miss     = miss;
    assign bus.estado       = estado;

endmodule

// File: tb/tb_controle_pc.sv
// Bench for controle_pc: directed scenarios then closed-loop random traffic vs a reference model.
module tb_controle_pc;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          RD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  controle_pc_if #(.XLEN(32)) bus ();

  controle_pc #(.XLEN(32), .RESET_VEC(RV), .TRAP_VEC(TV), .RAS_DEPTH(RD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  task automatic verifica(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  localparam int M_BOOT = 0, M_RUN = 1, M_TRAP = 2, M_HALT = 3;
  int          m_modo = M_BOOT;
  logic [31:0] m_epc  = 32'h0;
  logic [31:0] m_ras[$];
  logic [31:0] pc_r   = 32'h0;

  task automatic ras_push(input logic [31:0] v);
    if (m_ras.size() == RD) void'(m_ras.pop_front());
    m_ras.push_back(v);
  endtask

  // Inputs must already be applied; checks outputs, then advances the model one edge.
  task automatic ciclo();
    logic [31:0] a, e_pc, cand, e_epc;
    logic e_val, e_halt, e_miss, e_vaz, e_chei;
    #1;
    a      = bus.atual_Pc;
    e_val  = 1'b0;
    e_halt = 1'b0;
    e_miss = 1'b0;
    e_vaz  = (m_ras.size() == 0);
    e_chei = (m_ras.size() == RD);
    e_epc  = m_epc;
    e_pc   = a;
    if (rst) begin
      e_pc   = RV;
      m_modo = M_BOOT;
      m_epc  = 32'h0;
      m_ras.delete();
    end else begin
      case (m_modo)
        M_BOOT: begin
          e_pc   = RV;
          m_modo = M_RUN;
        end
        M_RUN: begin
          e_val = 1'b1;
          if (bus.halt || bus.stall)        cand = a;
          else if (bus.mret)                cand = m_epc;
          else if (bus.ret)                 cand = (m_ras.size() != 0) ? m_ras[$] : bus.jump_alvo;
          else if (bus.call || bus.jump)    cand = bus.jump_alvo;
          else if (bus.branch_taken)        cand = bus.branch_alvo;
          else                              cand = a + 32'd4;
          if (bus.trap || (cand % 4) != 0) begin
            e_pc   = TV;
            m_epc  = a;
            m_modo = M_TRAP;
          end else begin
            e_pc = cand;
            if (bus.halt) m_modo = M_HALT;
            else if (!bus.stall && !bus.mret) begin
              if (bus.ret) begin
                if (m_ras.size() == 0) e_miss = 1'b1;
                else void'(m_ras.pop_back());
              end
              if (bus.call) ras_push(a + 32'd4);
            end
          end
        end
        M_TRAP: begin
          e_pc   = a;
          m_modo = M_RUN;
        end
        default: begin
          e_halt = 1'b1;
          if (bus.trap) begin
            e_pc   = TV;
            m_epc  = a + 32'd4;
            m_modo = M_TRAP;
          end
        end
      endcase
    end
    exp_q.push_back(e_pc);
    verifica("proximo_Pc",   bus.proximo_Pc, exp_q.pop_front());
    verifica("instr_valida", 32'(bus.instr_valida), 32'(e_val));
    verifica("halted",       32'(bus.halted),       32'(e_halt));
    verifica("ras_miss",     32'(bus.ras_miss),     32'(e_miss));
    verifica("ras_vazio",    32'(bus.ras_vazio),    32'(e_vaz));
    verifica("ras_cheio",    32'(bus.ras_cheio),    32'(e_chei));
    verifica("epc",          bus.epc,               e_epc);
    pc_r = e_pc;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic limpa();
    bus.branch_taken = 1'b0;
    bus.branch_alvo  = 32'h0;
    bus.jump         = 1'b0;
    bus.call         = 1'b0;
    bus.jump_alvo    = 32'h0;
    bus.ret          = 1'b0;
    bus.trap         = 1'b0;
    bus.mret         = 1'b0;
    bus.stall        = 1'b0;
    bus.halt         = 1'b0;
  endtask

  task automatic em(input logic [31:0] a);
    limpa();
    bus.atual_Pc = a;
  endtask

  function automatic logic [31:0] alvo_rand();
    logic [31:0] v;
    v = $urandom() & 32'h0000_0FFC;
    if ($urandom_range(0, 15) == 0) v = v | 32'($urandom_range(1, 3));
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    em(32'h0);
    rst = 1'b1;
    @(negedge clk);

    // 1: reset, BOOT, sequential fetch
    ciclo(); ciclo();
    rst = 1'b0;
    em(32'h0); ciclo();
    em(32'h0); ciclo();
    em(32'h4); ciclo();

    // 2: jump outranks branch, then stall holds
    em(32'h20); bus.branch_taken = 1; bus.branch_alvo = 32'h40;
    bus.jump = 1; bus.jump_alvo = 32'h80; ciclo();
    em(32'h80); bus.stall = 1; ciclo();

    // 3: overflow the RAS, then drain it past empty
    for (int i = 1; i <= 5; i++) begin
      em(32'(i * 16)); bus.call = 1; bus.jump_alvo = 32'h200; ciclo();
    end
    for (int i = 0; i < 5; i++) begin
      em(32'h300); bus.ret = 1; bus.jump_alvo = 32'h400; ciclo();
    end

    // 4: trap, ignored second trap in the bubble, mret
    em(32'h1C); bus.trap = 1; ciclo();
    em(TV); bus.trap = 1; ciclo();
    em(TV); bus.mret = 1; ciclo();

    // 5: halt, ignored requests, trap wakes
    em(32'h60); bus.halt = 1; ciclo();
    em(32'h60); bus.stall = 1; bus.jump = 1; bus.jump_alvo = 32'h90; ciclo();
    em(32'h60); bus.trap = 1; ciclo();
    em(TV); ciclo();

    // 6: misaligned jump, reset from HALT with a loaded RAS, PC wrap
    em(32'h30); bus.jump = 1; bus.jump_alvo = 32'h42; ciclo();
    em(TV); ciclo();
    em(32'h10); bus.call = 1; bus.jump_alvo = 32'h200; ciclo();
    em(32'h200); bus.call = 1; bus.ret = 1; bus.jump_alvo = 32'h300; ciclo();
    em(32'h300); bus.call = 1; bus.jump_alvo = 32'h500; ciclo();
    em(32'h500); bus.halt = 1; ciclo();
    em(32'h500); ciclo();
    rst = 1'b1; em(32'h500); ciclo();
    rst = 1'b0; em(32'h0); ciclo();
    em(32'hFFFF_FFFC); ciclo();

    // closed-loop random traffic
    for (int n = 0; n < 800; n++) begin
      em(pc_r);
      if ($urandom_range(0, 31) == 0) bus.atual_Pc = $urandom() & 32'hFFFF_FFFC;
      bus.branch_taken = ($urandom_range(0, 5) == 0);
      bus.branch_alvo  = alvo_rand();
      bus.jump         = ($urandom_range(0, 7) == 0);
      bus.call         = ($urandom_range(0, 5) == 0);
      bus.jump_alvo    = alvo_rand();
      bus.ret          = ($urandom_range(0, 5) == 0);
      bus.trap         = ($urandom_range(0, 15) == 0);
      bus.mret         = ($urandom_range(0, 15) == 0);
      bus.stall        = ($urandom_range(0, 11) == 0);
      bus.halt         = ($urandom_range(0, 31) == 0);
      rst              = ($urandom_range(0, 99) == 0);
      ciclo();
    end
    rst = 1'b0;

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
